fsm_err_inject_ctrl: RTL and testbench

FSM_ERR_INJECT_CTRL -- requirements
Module: fsm_err_inject_ctrl

---
 rtl/fsm_test_pkg.sv | 20 ++
 rtl/sat_counter.sv | 26 ++
 rtl/fsm_err_inject_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fsm_err_inject_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_test_pkg.sv
// Shared types for the error-injection controller: FSM state encoding and result flag bit positions.
package fsm_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DELAY  = 3'd1,
        ST_INJECT = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_e;

    localparam int unsigned FLAGS_W     = 4;
    localparam int unsigned FLG_DATA    = 0;
    localparam int unsigned FLG_STATE   = 1;
    localparam int unsigned FLG_TIMEOUT = 2;
    localparam int unsigned FLG_SPUR    = 3;

    localparam int unsigned RST_SYNC_W  = 2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/fsm_err_inject_ctrl.sv
// Runs one inject/measure campaign per accepted start: wait, pulse the lane's error-inject
// strobe, measure detection latency (or time out) and hold the result until it is taken.
module fsm_err_inject_ctrl
    import fsm_test_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned WID_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   delay_i,
    input  logic [WID_W-1:0]   width_i,
    input  logic [CNT_W-1:0]   timeout_i,
    output logic               inj_err_o,
    input  logic               err_data_i,
    input  logic               err_state_i,
    output logic               busy_o,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [CNT_W-1:0]   res_latency_o,
    output logic [FLAGS_W-1:0] res_flags_o
);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [RST_SYNC_W-1:0]   r_rst_sync;
    logic                    w_armed;
    logic                    w_accept;
    logic                    w_err;

    logic [CNT_W-1:0]        r_delay;
    logic [WID_W-1:0]        r_width_m1;
    logic [CNT_W-1:0]        r_timeout;

    logic [CNT_W-1:0]        w_dly_cnt;
    logic [WID_W-1:0]        w_wid_cnt;
    logic [CNT_W-1:0]        w_lat_cnt;

    logic                    r_inj_err;
    logic                    r_busy;
    logic                    r_res_valid;
    logic [CNT_W-1:0]        r_res_latency;
    logic [FLAGS_W-1:0]      r_res_flags;
    logic [CNT_W-1:0]        w_res_latency_nxt;
    logic [FLAGS_W-1:0]      w_res_flags_nxt;

    // Reset release is retimed so a start right after release cannot race the FSM out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[RST_SYNC_W-2:0], 1'b1};
        end
    end

    assign w_armed  = r_rst_sync[RST_SYNC_W-1];
    assign w_err    = err_data_i | err_state_i;
    assign w_accept = (r_state == ST_IDLE) && start_i && w_armed;

    sat_counter #(.WIDTH(CNT_W)) u_dly_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (r_state != ST_DELAY),
        .en_i   (r_state == ST_DELAY),
        .cnt_o  (w_dly_cnt)
    );

    sat_counter #(.WIDTH(WID_W)) u_wid_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (r_state != ST_INJECT),
        .en_i   (r_state == ST_INJECT),
        .cnt_o  (w_wid_cnt)
    );

    // Latency is zero in the first strobe cycle because it is cleared on every cycle before it.
    sat_counter #(.WIDTH(CNT_W)) u_lat_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  ((r_state != ST_INJECT) && (r_state != ST_WAIT)),
        .en_i   ((r_state == ST_INJECT) || (r_state == ST_WAIT)),
        .cnt_o  (w_lat_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_delay    <= '0;
            r_width_m1 <= '0;
            r_timeout  <= '0;
        end else if (w_accept) begin
            r_delay    <= delay_i;
            r_width_m1 <= (width_i == '0) ? '0 : width_i - WID_W'(1);
            r_timeout  <= timeout_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_res_latency_nxt = r_res_latency;
        w_res_flags_nxt   = r_res_flags;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_res_latency_nxt = '0;
                    w_res_flags_nxt   = '0;
                    w_state_nxt       = (delay_i == '0) ? ST_INJECT : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (w_err) begin
                    w_res_flags_nxt[FLG_SPUR] = 1'b1;
                end
                if (w_dly_cnt == r_delay - CNT_W'(1)) begin
                    w_state_nxt = ST_INJECT;
                end
            end
            ST_INJECT, ST_WAIT: begin
                if (w_err) begin
                    w_res_latency_nxt          = w_lat_cnt;
                    w_res_flags_nxt[FLG_DATA]  = err_data_i;
                    w_res_flags_nxt[FLG_STATE] = err_state_i;
                    w_state_nxt                = ST_REPORT;
                end else if (r_state == ST_INJECT) begin
                    if (w_wid_cnt == r_width_m1) begin
                        w_state_nxt = ST_WAIT;
                    end
                end else if ((r_timeout != '0) && (w_lat_cnt >= r_timeout)) begin
                    w_res_latency_nxt            = r_timeout;
                    w_res_flags_nxt[FLG_TIMEOUT] = 1'b1;
                    w_state_nxt                  = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (res_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so each one comes straight from a flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inj_err     <= 1'b0;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_latency <= '0;
            r_res_flags   <= '0;
        end else begin
            r_inj_err     <= (w_state_nxt == ST_INJECT);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_res_valid   <= (w_state_nxt == ST_REPORT);
            r_res_latency <= w_res_latency_nxt;
            r_res_flags   <= w_res_flags_nxt;
        end
    end

    assign inj_err_o     = r_inj_err;
    assign busy_o        = r_busy;
    assign res_valid_o   = r_res_valid;
    assign res_latency_o = r_res_latency;
    assign res_flags_o   = r_res_flags;

endmodule

// File: tb/tb_fsm_err_inject_ctrl.sv
// Directed and randomized campaigns for fsm_err_inject_ctrl, checked against a cycle-indexed model.
module tb_fsm_err_inject_ctrl;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned WID_W   = 8;
    localparam int          LAT_MAX = (1 << CNT_W) - 1;
    localparam int          NCYC    = 1024;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic [CNT_W-1:0] delay_i;
    logic [WID_W-1:0] width_i;
    logic [CNT_W-1:0] timeout_i;
    logic             inj_err_o;
    logic             err_data_i;
    logic             err_state_i;
    logic             busy_o;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [CNT_W-1:0] res_latency_o;
    logic [3:0]       res_flags_o;

    bit sched_d [NCYC];
    bit sched_s [NCYC];
    int vecs        = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    fsm_err_inject_ctrl #(.CNT_W(CNT_W), .WID_W(WID_W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .delay_i       (delay_i),
        .width_i       (width_i),
        .timeout_i     (timeout_i),
        .inj_err_o     (inj_err_o),
        .err_data_i    (err_data_i),
        .err_state_i   (err_state_i),
        .busy_o        (busy_o),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_latency_o (res_latency_o),
        .res_flags_o   (res_flags_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_sched();
        for (int k = 0; k < NCYC; k++) begin
            sched_d[k] = 1'b0;
            sched_s[k] = 1'b0;
        end
    endtask

    // Error inputs for cycle k after the accept edge come from sched_d/sched_s[k].
    task automatic campaign(input int d, input int w, input int t, input int hold,
                            input bit start_at_hs, input int want_lat, input int want_flags);
        int         weff;
        int         jend;
        int         lat;
        int         exp_lat;
        logic [3:0] exp_flags;
        logic       exp_inj;

        weff      = (w == 0) ? 1 : w;
        exp_flags = 4'b0000;
        exp_lat   = 0;
        jend      = -1;
        for (int k = 0; k < d; k++) begin
            if (sched_d[k] || sched_s[k]) exp_flags[3] = 1'b1;
        end
        for (int j = 0; (d + j < NCYC) && (jend < 0); j++) begin
            lat = (j > LAT_MAX) ? LAT_MAX : j;
            if (sched_d[d + j] || sched_s[d + j]) begin
                jend         = j;
                exp_lat      = lat;
                exp_flags[0] = sched_d[d + j];
                exp_flags[1] = sched_s[d + j];
            end else if ((j >= weff) && (t != 0) && (lat >= t)) begin
                jend         = j;
                exp_lat      = t;
                exp_flags[2] = 1'b1;
            end
        end
        if (jend < 0) begin
            miscompares++;
            $display("FAIL schedule: campaign d=%0d w=%0d t=%0d never ends", d, w, t);
            return;
        end

        start_i   = 1'b1;
        delay_i   = CNT_W'(d);
        width_i   = WID_W'(w);
        timeout_i = CNT_W'(t);
        step();
        start_i   = 1'b0;
        for (int k = 0; k <= d + jend; k++) begin
            exp_inj = (k >= d) && (k - d < weff);
            check("inj_err", 32'(inj_err_o), 32'(exp_inj));
            check("busy_run", 32'(busy_o), 32'd1);
            check("valid_run", 32'(res_valid_o), 32'd0);
            err_data_i  = sched_d[k];
            err_state_i = sched_s[k];
            step();
        end
        err_data_i  = 1'b0;
        err_state_i = 1'b0;

        for (int h = 0; h <= hold; h++) begin
            check("rpt_valid", 32'(res_valid_o), 32'd1);
            check("rpt_latency", 32'(res_latency_o), 32'(exp_lat));
            check("rpt_flags", 32'(res_flags_o), 32'(exp_flags));
            check("rpt_inj", 32'(inj_err_o), 32'd0);
            if (h < hold) begin
                res_ready_i = 1'b0;
                start_i     = h[0];
                err_data_i  = 1'($urandom_range(0, 1));
                err_state_i = 1'($urandom_range(0, 1));
            end else begin
                res_ready_i = 1'b1;
                start_i     = start_at_hs;
                err_data_i  = 1'b0;
                err_state_i = 1'b0;
            end
            step();
        end
        if (want_lat >= 0) check("dir_latency", 32'(res_latency_o), 32'(want_lat));
        if (want_flags >= 0) check("dir_flags", 32'(res_flags_o), 32'(want_flags));
        res_ready_i = 1'b0;
        start_i     = 1'b0;
        err_data_i  = 1'b0;
        err_state_i = 1'b0;
        check("hs_valid", 32'(res_valid_o), 32'd0);
        check("hs_busy", 32'(busy_o), 32'd0);
        step();
        check("idle_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         d;
        int         w;
        int         weff;
        int         t;
        int         mode;
        int         jd;
        logic [1:0] pick;

        rst_ni      = 1'b0;
        start_i     = 1'b0;
        delay_i     = '0;
        width_i     = '0;
        timeout_i   = '0;
        err_data_i  = 1'b0;
        err_state_i = 1'b0;
        res_ready_i = 1'b0;
        step();
        step();
        check("rst_inj", 32'(inj_err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(res_valid_o), 32'd0);
        check("rst_latency", 32'(res_latency_o), 32'd0);
        check("rst_flags", 32'(res_flags_o), 32'd0);
        rst_ni = 1'b1;
        step();
        step();
        step();

        // Directed scenarios.
        clr_sched();
        sched_s[10 + 3] = 1'b1;
        campaign(10, 2, 100, 1, 1'b0, 3, 4'b0010);

        clr_sched();
        campaign(0, 1, 20, 0, 1'b0, 20, 4'b0100);

        clr_sched();
        sched_d[2]     = 1'b1;
        sched_d[6 + 5] = 1'b1;
        campaign(6, 3, 100, 2, 1'b0, 5, 4'b1001);

        clr_sched();
        sched_d[4 + 1] = 1'b1;
        sched_s[4 + 1] = 1'b1;
        campaign(4, 8, 0, 0, 1'b0, 1, 4'b0011);

        clr_sched();
        campaign(3, 0, 5, 0, 1'b0, 5, 4'b0100);

        clr_sched();
        sched_d[300] = 1'b1;
        campaign(0, 1, 0, 0, 1'b0, LAT_MAX, 4'b0001);

        clr_sched();
        sched_s[5 + 7] = 1'b1;
        campaign(5, 4, 0, 50, 1'b1, 7, 4'b0010);
        clr_sched();
        sched_d[2 + 2] = 1'b1;
        campaign(2, 3, 40, 0, 1'b0, 2, 4'b0001);

        // Reset in the middle of an injection pulse.
        clr_sched();
        start_i   = 1'b1;
        delay_i   = '0;
        width_i   = WID_W'(8);
        timeout_i = '0;
        step();
        start_i = 1'b0;
        check("mid_inj_on", 32'(inj_err_o), 32'd1);
        step();
        step();
        rst_ni = 1'b0;
        #1;
        check("mid_rst_inj", 32'(inj_err_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_valid", 32'(res_valid_o), 32'd0);
        check("mid_rst_latency", 32'(res_latency_o), 32'd0);
        check("mid_rst_flags", 32'(res_flags_o), 32'd0);
        step();
        step();
        rst_ni  = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("early_start_busy", 32'(busy_o), 32'd0);
        step();
        step();
        step();
        clr_sched();
        sched_d[1 + 2] = 1'b1;
        campaign(1, 2, 0, 0, 1'b0, 2, 4'b0001);

        // Randomized campaigns.
        for (int n = 0; n < 24; n++) begin
            clr_sched();
            d    = int'($urandom_range(0, 15));
            w    = int'($urandom_range(0, 12));
            weff = (w == 0) ? 1 : w;
            mode = int'($urandom_range(0, 2));
            for (int k = 0; k < d; k++) begin
                sched_d[k] = ($urandom_range(0, 7) == 0);
                sched_s[k] = ($urandom_range(0, 7) == 0);
            end
            t = (mode == 0) ? 0 : int'($urandom_range(weff, weff + 30));
            if (mode != 1) begin
                jd   = int'($urandom_range(0, weff + 40));
                pick = 2'($urandom_range(1, 3));
                sched_d[d + jd] = pick[0];
                sched_s[d + jd] = pick[1];
            end
            campaign(d, w, t, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
